// File: rtl/bitmap_scan_reader.sv
// Display-side reader for the 256x256 4bpp bitmap RAM: fetches one scanline of
// 16-bit words through the arbiter, buffers two words and serialises pixels.
module bitmap_scan_reader #(
    parameter int WORDS_PER_LINE = 64,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        line_start,
    input  logic [7:0]  vline,
    input  logic [7:0]  hscroll,
    input  logic [7:0]  vscroll,
    output logic        rd_req,
    output logic [13:0] rd_addr,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [3:0]  pix_out,
    output logic        pix_valid,
    output logic        underflow
);
    localparam int PIX_PER_LINE = WORDS_PER_LINE * 4;
    localparam int WL_W = $clog2(WORDS_PER_LINE + 2);
    localparam int PL_W = $clog2(PIX_PER_LINE + 1);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;
    state_t state_reg, state_next;

    logic [7:0]      row_reg;
    logic [5:0]      col_reg;
    logic [1:0]      k_reg;
    logic [WL_W-1:0] words_left_reg;
    logic [PL_W-1:0] pix_left_reg;
    logic            outstanding_reg;
    logic            discard_reg;
    logic            restart_reg;
    logic [1:0]      wr_ptr_reg;
    logic [1:0]      rd_ptr_reg;
    logic [15:0]     fifo_mem [2];
    logic [3:0]      pix_out_reg;
    logic            pix_valid_reg;
    logic            underflow_reg;

    logic [1:0]  fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic [15:0] head_word;
    logic [3:0]  head_nib [4];
    logic        ack_fire;
    logic        run_pix;
    logic        last_pix;
    logic        push;
    logic        pop;
    logic        flush;

    // Pointers carry a wrap bit, so the difference is the occupancy 0..2.
    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_full  = (fifo_count == DEPTH);
    assign head_word  = fifo_mem[rd_ptr_reg[0]];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign head_nib[gi] = head_word[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_req     = 1'b0;
        ack_fire   = 1'b0;
        run_pix    = 1'b0;
        last_pix   = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        push       = 1'b0;

        // restart_reg blanks the request for one cycle after a line restart.
        rd_req   = (state_reg != IDLE) && (words_left_reg != '0) && !outstanding_reg &&
                   !restart_reg &&
                   (({1'b0, fifo_count} + {2'b00, outstanding_reg}) < {1'b0, DEPTH});
        ack_fire = rd_req && rd_ack;
        run_pix  = (state_reg == RUN) && pix_ce && !line_start;
        last_pix = run_pix && (pix_left_reg == PL_W'(1));
        pop      = run_pix && !fifo_empty && (k_reg == 2'd3);
        flush    = line_start || last_pix;
        push     = rd_valid && outstanding_reg && !discard_reg && (state_reg != IDLE) && !flush;

        if (line_start) begin
            state_next = PREFETCH;
        end else begin
            case (state_reg)
                PREFETCH: if (fifo_full) state_next = RUN;
                RUN:      if (last_pix) state_next = IDLE;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg         <= '0;
            col_reg         <= '0;
            k_reg           <= '0;
            words_left_reg  <= '0;
            pix_left_reg    <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
            restart_reg     <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            pix_out_reg     <= '0;
            pix_valid_reg   <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            restart_reg <= line_start;

            if (ack_fire) begin
                outstanding_reg <= 1'b1;
            end else if (rd_valid) begin
                outstanding_reg <= 1'b0;
            end

            // A read still in flight across a restart belongs to the old line.
            if (line_start) begin
                discard_reg <= (outstanding_reg && !rd_valid) || ack_fire;
            end else if (rd_valid) begin
                discard_reg <= 1'b0;
            end

            if (line_start) begin
                row_reg        <= vline + vscroll;
                col_reg        <= hscroll[7:2];
                k_reg          <= hscroll[1:0];
                words_left_reg <= WL_W'(WORDS_PER_LINE) + WL_W'(hscroll[1:0] != 2'b00);
                pix_left_reg   <= PL_W'(PIX_PER_LINE);
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                pix_out_reg    <= '0;
                pix_valid_reg  <= 1'b0;
            end else begin
                if (ack_fire) begin
                    col_reg        <= col_reg + 6'd1;
                    words_left_reg <= words_left_reg - WL_W'(1);
                end

                if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
                end

                if (pix_ce) begin
                    if (state_reg == RUN) begin
                        pix_valid_reg <= 1'b1;
                        pix_out_reg   <= fifo_empty ? 4'd0 : head_nib[k_reg];
                        underflow_reg <= underflow_reg | fifo_empty;
                        k_reg         <= k_reg + 2'd1;
                        pix_left_reg  <= pix_left_reg - PL_W'(1);
                    end else begin
                        pix_valid_reg <= 1'b0;
                        pix_out_reg   <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[0]] <= rd_data;
        end
    end

    assign rd_addr   = {row_reg, col_reg};
    assign pix_out   = pix_out_reg;
    assign pix_valid = pix_valid_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_bitmap_scan_reader.sv
// Randomised bench for bitmap_scan_reader: behavioural arbiter/RAM plus a
// per-line pixel model derived from row/column/scroll arithmetic.
module tb_bitmap_scan_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic        line_start;
    logic [7:0]  vline, hscroll, vscroll;
    logic        rd_req;
    logic [13:0] rd_addr;
    logic        rd_ack, rd_valid;
    logic [15:0] rd_data;
    logic [3:0]  pix_out;
    logic        pix_valid, underflow;

    bitmap_scan_reader dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .line_start(line_start),
        .vline(vline), .hscroll(hscroll), .vscroll(vscroll),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .pix_out(pix_out), .pix_valid(pix_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // line model
    int          line_id = 0;
    logic [7:0]  row_m;
    int          col0_m, fine_m, nwords_m;
    int          acks_line, ret_line, pix_j;
    bit          line_active = 0, idle_exp = 1, chk_pix = 1, lit_mod4 = 0, ram_const = 0;
    bit          uf_exp = 0, uf_chk = 0, uf_watch = 0;
    logic [13:0] first_addr, last_addr;
    logic [3:0]  first_pix;

    // arbiter model
    bit          armed = 0, ret_busy = 0;
    int          ack_cnt, ret_cnt, ret_id;
    logic [15:0] ret_data;
    int          ack_min = 0, ack_max = 0, val_min = 1, val_max = 1;
    int          pix_period = 0, pix_phase = 0;

    logic        prev_req = 0, prev_uf = 0;
    logic [13:0] prev_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ram_word(input logic [13:0] a);
        logic [31:0] t;
        if (ram_const) return 16'h3210;
        t = {18'b0, a} * 32'h9E37 + 32'h1234;
        return t[23:8];
    endfunction

    // Pixel j of the line: screen x = hscroll + j, wrapping within the 64-word row.
    function automatic logic [3:0] exp_pix(input int j);
        int p;
        logic [13:0] a;
        logic [15:0] w;
        p = fine_m + j;
        a = {row_m, 6'((col0_m + p / 4) % 64)};
        w = ram_word(a);
        return w[4*(p%4) +: 4];
    endfunction

    task automatic tick();
        logic [13:0] ea;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_ack   = 1'b0;
        if (ret_busy) begin
            ret_cnt--;
            if (ret_cnt <= 0) begin
                rd_valid = 1'b1;
                rd_data  = ret_data;
                ret_busy = 0;
                if (ret_id == line_id) ret_line++;
            end
        end
        if (rd_req) begin
            if (!armed) begin
                armed   = 1;
                ack_cnt = $urandom_range(ack_max, ack_min);
            end
            if (ack_cnt == 0) begin
                rd_ack = 1'b1;
                armed  = 0;
                chk("one_outstanding", 32'(ret_busy), 0);
                ea = {row_m, 6'((col0_m + acks_line) % 64)};
                chk("rd_addr", 32'(rd_addr), 32'(ea));
                if (acks_line == 0) first_addr = rd_addr;
                last_addr = rd_addr;
                acks_line++;
                ret_busy = 1;
                ret_cnt  = $urandom_range(val_max, val_min);
                ret_data = ram_word(rd_addr);
                ret_id   = line_id;
            end else begin
                ack_cnt--;
            end
        end else begin
            armed = 0;
        end
        pix_ce = 1'b0;
        if (pix_period > 0) begin
            pix_phase++;
            if (pix_phase >= pix_period) begin
                pix_phase = 0;
                pix_ce = 1'b1;
            end
        end
    endtask

    task automatic start_line(input logic [7:0] v, input logic [7:0] h, input logic [7:0] vs);
        vline = v; hscroll = h; vscroll = vs; line_start = 1'b1;
        line_id++;
        row_m = 8'(v + vs);
        col0_m = int'(h[7:2]);
        fine_m = int'(h[1:0]);
        nwords_m = 64 + ((h[1:0] != 2'b00) ? 1 : 0);
        acks_line = 0; ret_line = 0; pix_j = 0;
        line_active = 1; idle_exp = 0;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_line();
        for (int c = 0; c < 3000 && line_active; c++) tick();
        if (line_active) begin
            vectors++; miscompares++;
            $display("FAIL line_timeout: got %0d pixels required 256", pix_j);
            line_active = 0; idle_exp = 1;
        end
        repeat (8) tick();
        for (int c = 0; c < 100 && ret_busy; c++) tick();
    endtask

    task automatic set_arb(input int amin, input int amax, input int vmin, input int vmax, input int pp);
        ack_min = amin; ack_max = amax; val_min = vmin; val_max = vmax; pix_period = pp;
    endtask

    // Compare process: sampled 1 time unit after every active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_req = 1'b0;
                prev_uf  = 1'b0;
            end else begin
                if (prev_req && !rd_ack && !line_start) begin
                    chk("req_hold", 32'(rd_req), 1);
                    chk("addr_hold", 32'(rd_addr), 32'(prev_addr));
                end
                if (line_start) chk("req_drop", 32'(rd_req), 0);
                if (idle_exp) chk("req_idle", 32'(rd_req), 0);
                if (uf_chk) chk("underflow", 32'(underflow), 32'(uf_exp));
                if (uf_watch && !prev_uf && underflow) begin
                    chk("uf_pix_out", 32'(pix_out), 0);
                    chk("uf_pix_valid", 32'(pix_valid), 1);
                end
                if (pix_ce) begin
                    if (!line_active) begin
                        chk("pix_valid_idle", 32'(pix_valid), 0);
                    end else if (pix_valid) begin
                        if (pix_j == 0) chk("prefetch_full", 32'(ret_line >= 2), 1);
                        if (chk_pix) chk("pix_out", 32'(pix_out), 32'(exp_pix(pix_j)));
                        if (lit_mod4) chk("pix_lit", 32'(pix_out), 32'(pix_j % 4));
                        if (pix_j == 0) first_pix = pix_out;
                        pix_j++;
                        if (pix_j == 256) begin
                            line_active = 0;
                            idle_exp = 1;
                        end
                    end else begin
                        chk("pix_gap", 32'(pix_j), 0);
                    end
                end
                prev_req  = rd_req;
                prev_addr = rd_addr;
                prev_uf   = underflow;
            end
        end
    end

    initial begin
        int c;
        logic [7:0] v, h, vs;
        reset = 1'b1; pix_ce = 1'b0; line_start = 1'b0;
        vline = '0; hscroll = '0; vscroll = '0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_pix_out", 32'(pix_out), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_underflow", 32'(underflow), 0);
        uf_chk = 1; uf_exp = 0;

        // Plain line, constant RAM pattern
        ram_const = 1; lit_mod4 = 1;
        set_arb(0, 2, 1, 3, 3);
        start_line(8'h10, 8'h00, 8'h00);
        wait_line();
        chk("t1_acks", 32'(acks_line), 64);
        chk("t1_first_addr", 32'(first_addr), 32'h0400);
        chk("t1_last_addr", 32'(last_addr), 32'h043F);
        chk("t1_pixels", 32'(pix_j), 256);
        lit_mod4 = 0;

        // Scroll on both axes with fine offset and horizontal wrap
        start_line(8'h10, 8'h06, 8'hF8);
        wait_line();
        chk("t2_acks", 32'(acks_line), 65);
        chk("t2_first_addr", 32'(first_addr), 32'h0201);
        chk("t2_last_addr", 32'(last_addr), 32'h0201);
        chk("t2_first_pix", 32'(first_pix), 2);
        ram_const = 0;

        // Slow arbiter: ack held off 5 cycles per request
        set_arb(5, 5, 2, 2, 6);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        wait_line();
        chk("t3_acks", 32'(acks_line), 32'(nwords_m));

        // Random lines
        for (int n = 0; n < 4; n++) begin
            set_arb(0, 3, 1, 4, $urandom_range(6, 3));
            start_line(8'($urandom), 8'($urandom), 8'($urandom));
            wait_line();
            chk("rand_acks", 32'(acks_line), 32'(nwords_m));
        end

        // Restart mid-RUN while a read is acked but not returned
        set_arb(0, 1, 6, 6, 4);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        for (c = 0; c < 2000 && !(pix_j >= 10 && ret_busy && ret_cnt >= 2); c++) tick();
        chk("t5_setup_reached", 32'(c < 2000), 1);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        wait_line();
        chk("t5_acks", 32'(acks_line), 32'(nwords_m));

        // Starvation: slow returns, pixel every cycle
        uf_chk = 0; chk_pix = 0; uf_watch = 1;
        set_arb(0, 0, 12, 12, 1);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        wait_line();
        chk("t4_underflow", 32'(underflow), 1);
        chk("t4_pixels", 32'(pix_j), 256);
        uf_exp = 1; uf_chk = 1; chk_pix = 1; uf_watch = 0;
        set_arb(0, 3, 1, 4, 4);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        wait_line();
        chk("uf_sticky", 32'(underflow), 1);

        // Reset while in RUN with a request pending
        set_arb(3, 5, 1, 4, 4);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        for (c = 0; c < 3000 && !(pix_j >= 20 && rd_req && !rd_ack); c++) tick();
        chk("t6_setup_reached", 32'(c < 3000), 1);
        reset = 1'b1;
        line_active = 0; idle_exp = 1; uf_exp = 0; line_id++;
        tick();
        reset = 1'b0;
        chk("t6_rd_req", 32'(rd_req), 0);
        chk("t6_pix_valid", 32'(pix_valid), 0);
        chk("t6_underflow", 32'(underflow), 0);
        chk("t6_rd_addr", 32'(rd_addr), 0);
        if (!ret_busy) begin
            ret_busy = 1; ret_cnt = 3; ret_data = 16'hFFFF; ret_id = -1;
        end
        repeat (20) tick();
        chk("t6_still_idle", 32'(pix_valid), 0);
        set_arb(0, 3, 1, 4, 3);
        start_line(8'($urandom), 8'($urandom), 8'($urandom));
        wait_line();
        chk("t6_acks", 32'(acks_line), 32'(nwords_m));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
